// File: rtl/ustc_pkg.sv
// ---------------------------------------------------------------------------
// ustc_pkg
// Shared sizing, lane-field layout and state encodings for the USTC output
// accumulation path (ustc_acc_buffer and its reduction sub-module).
//
// Lane layout inside the packed fan output word (one lane = DW_OUT bits):
//   [OFF_DATA +: DW_DATA]  signed product
//   [OFF_ROW  +: DW_ROW ]  destination row index
//   [OFF_CTRL +: DW_CTRL]  ctrl: bit CTRL_VALID = lane valid,
//                                bit CTRL_LAST  = tile last (lane 0 only)
// ---------------------------------------------------------------------------
package ustc_pkg;

  // Datapath sizing
  localparam int N_UNIT  = 32;
  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 4;
  localparam int DW_CTRL = 4;
  localparam int DW_OUT  = 16;
  localparam int DW_ACC  = 24;

  localparam int N_ROW   = 1 << DW_ROW;
  // Width of one per-row beat sum: enough headroom for N_UNIT products
  localparam int DW_SUM  = DW_DATA + $clog2(N_UNIT);

  // Lane field offsets
  localparam int OFF_DATA = 0;
  localparam int OFF_ROW  = OFF_DATA + DW_DATA;
  localparam int OFF_CTRL = OFF_ROW + DW_ROW;

  // Ctrl bit positions
  localparam int CTRL_VALID = 0;
  localparam int CTRL_LAST  = 1;

  // Per-bank lifecycle
  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_ACCUM = 2'd1,
    BANK_FULL  = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_state_t;

  // Drain sequencer
  typedef enum logic {
    DR_IDLE  = 1'b0,
    DR_DRAIN = 1'b1
  } drain_state_t;

  typedef logic [N_UNIT-1:0][DW_DATA-1:0] lane_prod_t;
  typedef logic [N_UNIT-1:0][DW_ROW-1:0]  lane_row_t;
  typedef logic [N_ROW-1:0][DW_SUM-1:0]   row_sums_t;
  typedef logic [N_ROW-1:0][DW_ACC-1:0]   bank_acc_t;

  // A bank can take new products only before its tile has been closed
  function automatic logic bank_writable(bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_ACCUM);
  endfunction

endpackage

// File: rtl/ustc_acc_reduce.sv
// ---------------------------------------------------------------------------
// ustc_acc_reduce
// Combinational per-row masked reduction. Every valid lane adds its
// sign-extended product into the sum of the row it targets; rows no lane
// targets read 0.
//
// Ports:
//   product  in   N_UNIT x DW_DATA  signed product per lane
//   row      in   N_UNIT x DW_ROW   target row per lane
//   valid    in   N_UNIT            lane valid mask
//   sums     out  N_ROW  x DW_SUM   signed per-row sums
// ---------------------------------------------------------------------------
module ustc_acc_reduce
  import ustc_pkg::*;
(
  input  lane_prod_t        product,
  input  lane_row_t         row,
  input  logic [N_UNIT-1:0] valid,
  output row_sums_t         sums
);

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sums = '0;
    for (int r = 0; r < N_ROW; r++) begin
      for (int i = 0; i < N_UNIT; i++) begin
        if (valid[i] && (row[i] == DW_ROW'(r))) begin
          // Sized cast of a signed operand sign-extends the product
          sums[r] = sums[r] + DW_SUM'($signed(product[i]));
        end
      end
    end
  end

endmodule

// File: rtl/ustc_acc_buffer.sv
// ---------------------------------------------------------------------------
// ustc_acc_buffer
// Output accumulation stage behind the USTC array. Each input beat is reduced
// by row index and added into the active bank of a ping-pong accumulator.
// A beat flagged "last" closes the tile: the bank becomes FULL, writes move
// to the other bank, and the FULL bank is drained row by row over a
// valid/ready stream.
//
// Pipeline: S1 registers the beat together with in_ready; S2 reduces and
// commits one cycle later. The drain sequencer picks a FULL bank the cycle
// after it turns FULL, so out_valid rises 3 cycles after a last beat.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in           in   N_UNIT lanes of {ctrl, row, product}, DW_OUT pitch
//   in_ready     out  write-target bank can accept products
//   out_valid    out  drain beat valid
//   out_ready    in   drain beat accepted
//   out_data     out  accumulated row value
//   out_row      out  row index of out_data
//   out_last     out  final row of the bank being drained
//   err_overrun  out  sticky: a beat with valid lanes was dropped
//   err_sat      out  sticky: an accumulation clipped (USTC_ACC_SAT_EN only)
//
// Configuration macro: USTC_ACC_SAT_EN
//   defined   -> saturating accumulation plus err_sat output
//   undefined -> accumulation wraps modulo 2^DW_ACC, no err_sat port
// ---------------------------------------------------------------------------
module ustc_acc_buffer
  import ustc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_UNIT*DW_OUT-1:0] in,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW_ACC-1:0]        out_data,
  output logic [DW_ROW-1:0]        out_row,
  output logic                     out_last,
  output logic                     err_overrun
`ifdef USTC_ACC_SAT_EN
  ,
  output logic                     err_sat
`endif
);

  // -------------------------------------------------------------------------
  // Lane unpacking
  // -------------------------------------------------------------------------
  lane_prod_t        in_prod;
  lane_row_t         in_row;
  logic [N_UNIT-1:0] in_vld;
  logic              in_last;

  always_comb begin
    in_prod = '0;
    in_row  = '0;
    in_vld  = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      in_prod[i] = in[i*DW_OUT + OFF_DATA +: DW_DATA];
      in_row[i]  = in[i*DW_OUT + OFF_ROW  +: DW_ROW];
      in_vld[i]  = in[i*DW_OUT + OFF_CTRL + CTRL_VALID];
    end
    // Tile last is honoured on lane 0 only, and only when lane 0 is valid
    in_last = in[OFF_CTRL + CTRL_VALID] && in[OFF_CTRL + CTRL_LAST];
  end

  // Ctrl bits 3:2 and the last bit of lanes 1..N_UNIT-1 carry no meaning here
  logic unused_in_bits;
  assign unused_in_bits = ^in;

  // -------------------------------------------------------------------------
  // Bank bookkeeping (declared early: in_ready feeds S1)
  // -------------------------------------------------------------------------
  bank_state_t bank_st  [2];
  bank_state_t bank_nxt [2];
  logic        wr_ptr;        // bank receiving products
  logic        rd_ptr;        // oldest bank, next one to drain
  bank_acc_t   acc      [2];

  assign in_ready = bank_writable(bank_st[wr_ptr]);

  // -------------------------------------------------------------------------
  // S1: register the beat and the in_ready seen with it
  // -------------------------------------------------------------------------
  lane_prod_t        s1_prod;
  lane_row_t         s1_row;
  logic [N_UNIT-1:0] s1_vld;
  logic              s1_last;
  logic              s1_rdy;

  // NOTE: clocked state is always written with <=, so every flop samples the
  // pre-edge value of every other flop regardless of process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_prod <= '0;
      s1_row  <= '0;
      s1_vld  <= '0;
      s1_last <= 1'b0;
      s1_rdy  <= 1'b0;
    end else begin
      s1_prod <= in_prod;
      s1_row  <= in_row;
      s1_vld  <= in_vld;
      s1_last <= in_last;
      s1_rdy  <= in_ready;
    end
  end

  // -------------------------------------------------------------------------
  // S2: reduce, then commit into the write bank
  // -------------------------------------------------------------------------
  row_sums_t s2_sums;

  ustc_acc_reduce u_reduce (
    .product (s1_prod),
    .row     (s1_row),
    .valid   (s1_vld),
    .sums    (s2_sums)
  );

  logic s1_any_vld;
  logic s2_wr_ok;
  logic s2_commit;
  logic s2_drop;

  assign s1_any_vld = |s1_vld;
  // The write bank is re-checked here: a last beat still in flight may have
  // moved wr_ptr onto a bank that is FULL or draining since S1 sampled it.
  assign s2_wr_ok   = s1_rdy && bank_writable(bank_st[wr_ptr]);
  assign s2_commit  = s2_wr_ok && (s1_any_vld || s1_last);
  assign s2_drop    = !s2_wr_ok && s1_any_vld;

  bank_acc_t acc_upd;

`ifdef USTC_ACC_SAT_EN
  logic signed [DW_ACC:0] acc_wide [N_ROW];
  logic [N_ROW-1:0]       row_sat;

  always_comb begin
    acc_upd = '0;
    row_sat = '0;
    for (int r = 0; r < N_ROW; r++) begin
      acc_wide[r] = (DW_ACC+1)'($signed(acc[wr_ptr][r]))
                  + (DW_ACC+1)'($signed(s2_sums[r]));
      acc_upd[r]  = acc_wide[r][DW_ACC-1:0];
      // Overflow when the guard bit disagrees with the result sign bit;
      // the guard bit gives the true sign and picks the rail.
      if (acc_wide[r][DW_ACC] != acc_wide[r][DW_ACC-1]) begin
        row_sat[r] = 1'b1;
        acc_upd[r] = acc_wide[r][DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}}
                                         : {1'b0, {(DW_ACC-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sat <= 1'b0;
    end else if (s2_commit && (|row_sat)) begin
      err_sat <= 1'b1;
    end
  end
`else
  always_comb begin
    acc_upd = '0;
    for (int r = 0; r < N_ROW; r++) begin
      acc_upd[r] = acc[wr_ptr][r] + DW_ACC'($signed(s2_sums[r]));
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overrun <= 1'b0;
    end else if (s2_drop) begin
      err_overrun <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Drain sequencer: state register / next state / outputs
  // -------------------------------------------------------------------------
  drain_state_t      dr_st;
  drain_state_t      dr_nxt;
  logic [DW_ROW-1:0] cnt;
  logic              drain_start;
  logic              drain_accept;
  logic              drain_done;

  assign drain_start  = (dr_st == DR_IDLE) && (bank_st[rd_ptr] == BANK_FULL);
  assign drain_accept = out_valid && out_ready;
  assign drain_done   = drain_accept && (cnt == DW_ROW'(N_ROW-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dr_st  <= DR_IDLE;
      cnt    <= '0;
      rd_ptr <= 1'b0;
    end else begin
      dr_st <= dr_nxt;
      if (drain_accept) begin
        // Wraps to 0 after the last row, ready for the next bank
        cnt <= cnt + 1'b1;
      end
      if (drain_done) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_comb begin
    dr_nxt = dr_st;
    unique case (dr_st)
      DR_IDLE:  if (drain_start) dr_nxt = DR_DRAIN;
      DR_DRAIN: if (drain_done)  dr_nxt = DR_IDLE;
      default:  dr_nxt = DR_IDLE;
    endcase
  end

  // Outputs come straight from registers, so they hold while out_ready is low
  // and return to their idle values as soon as reset is asserted.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_last  = 1'b0;
    if (dr_st == DR_DRAIN) begin
      out_valid = 1'b1;
      out_data  = acc[rd_ptr][cnt];
      out_row   = cnt;
      out_last  = (cnt == DW_ROW'(N_ROW-1));
    end
  end

  // -------------------------------------------------------------------------
  // Bank state and pointers
  // -------------------------------------------------------------------------
  // Writes only touch a writable bank and drain only touches a FULL/DRAIN
  // bank, so the two updates below never target the same bank.
  always_comb begin
    bank_nxt = bank_st;
    if (s2_commit) begin
      if (s1_last) begin
        bank_nxt[wr_ptr] = BANK_FULL;
      end else begin
        bank_nxt[wr_ptr] = BANK_ACCUM;
      end
    end
    if (drain_start) begin
      bank_nxt[rd_ptr] = BANK_DRAIN;
    end
    if (drain_done) begin
      bank_nxt[rd_ptr] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_ptr     <= 1'b0;
    end else begin
      bank_st <= bank_nxt;
      if (s2_commit && s1_last) begin
        wr_ptr <= ~wr_ptr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Accumulator storage
  // -------------------------------------------------------------------------
  // NOTE: the accumulator array is reset like any flop because an abandoned
  // tile must not leak partial sums into the next one; a drained row is also
  // zeroed on acceptance so the bank re-enters EMPTY clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc[0] <= '0;
      acc[1] <= '0;
    end else begin
      if (s2_commit) begin
        acc[wr_ptr] <= acc_upd;
      end
      if (drain_accept) begin
        acc[rd_ptr][cnt] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ustc_acc_buffer.sv
// ---------------------------------------------------------------------------
// tb_ustc_acc_buffer
// Scoreboard bench for ustc_acc_buffer. Stimulus pushes the hand-computed
// rows of every tile it expects to be drained; an independent monitor pops
// and compares on every accepted drain beat. Timing, backpressure, overrun
// and reset behaviour are compared directly by the stimulus process.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ustc_acc_buffer;
  import ustc_pkg::*;

  typedef struct packed {
    logic [DW_ACC-1:0] data;
    logic [DW_ROW-1:0] row;
    logic              last;
  } exp_beat_t;

  logic                     clk;
  logic                     reset;
  logic [N_UNIT*DW_OUT-1:0] in_w;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [DW_ACC-1:0]        out_data;
  logic [DW_ROW-1:0]        out_row;
  logic                     out_last;
  logic                     err_overrun;
`ifdef USTC_ACC_SAT_EN
  logic                     err_sat;
`endif

  ustc_acc_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_w),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_last    (out_last),
    .err_overrun (err_overrun)
`ifdef USTC_ACC_SAT_EN
    ,
    .err_sat     (err_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        tests = 0;
  int        fails = 0;
  exp_beat_t sb[$];
  int        exp_rows[N_ROW];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one comparison per accepted drain beat
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: row %0d data 0x%0h with empty scoreboard",
                 out_row, out_data);
      end else begin
        exp_beat_t e;
        e = sb.pop_front();
        check($sformatf("drain_row%0d_data", e.row), 32'(out_data), 32'(e.data));
        check("drain_row", 32'(out_row), 32'(e.row));
        check($sformatf("drain_row%0d_last", e.row), 32'(out_last), 32'(e.last));
      end
    end
  end

  // --- stimulus helpers ----------------------------------------------------
  function automatic logic [DW_OUT-1:0] lane(input int prod, input int row,
                                             input logic v, input logic l);
    logic [DW_OUT-1:0] w;
    w = '0;
    w[OFF_DATA +: DW_DATA]  = DW_DATA'(prod);
    w[OFF_ROW  +: DW_ROW]   = DW_ROW'(row);
    w[OFF_CTRL + CTRL_VALID] = v;
    w[OFF_CTRL + CTRL_LAST]  = l;
    return w;
  endfunction

  // All lanes valid, lane i -> row i%16, every product = prod
  function automatic logic [N_UNIT*DW_OUT-1:0] word_spread(input int prod,
                                                           input logic last);
    logic [N_UNIT*DW_OUT-1:0] w;
    w = '0;
    for (int i = 0; i < N_UNIT; i++)
      w[i*DW_OUT +: DW_OUT] = lane(prod, i % N_ROW, 1'b1, last && (i == 0));
    return w;
  endfunction

  // Present one beat for exactly one clock edge
  task automatic beat(input logic [N_UNIT*DW_OUT-1:0] w);
    in_w = w;
    @(posedge clk);
    #1 in_w = '0;
  endtask

  task automatic push_tile();
    for (int r = 0; r < N_ROW; r++)
      sb.push_back('{data: DW_ACC'(exp_rows[r]), row: DW_ROW'(r),
                     last: (r == N_ROW-1)});
  endtask

  task automatic set_rows(input int v);
    for (int r = 0; r < N_ROW; r++) exp_rows[r] = v;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_complete_sb_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1 sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --- directed tests ------------------------------------------------------
  initial begin
    logic [N_UNIT*DW_OUT-1:0] w;
    int n;
    reset     = 1'b0;
    out_ready = 1'b1;
    in_w      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_data",    32'(out_data),    32'd0);
    check("rst_out_row",     32'(out_row),     32'd0);
    check("rst_out_last",    32'(out_last),    32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1) single tile, last on the same beat: rows 0..15 = 2 each
    set_rows(2);
    push_tile();
    beat(word_spread(1, 1'b1));
    @(negedge clk); check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_cycle2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_cycle3_valid", 32'(out_valid), 32'd1);
    wait_drained(100);

    // 2) signed accumulate: row 5 gets -128 on four beats
    set_rows(0);
    exp_rows[5] = 32'hFFFE00;
    push_tile();
    for (int k = 0; k < 4; k++) begin
      w = '0;
      w[0 +: DW_OUT] = lane(-128, 5, 1'b1, k == 3);
      beat(w);
    end
    wait_drained(100);

    // 3) backpressure at row 7: lane i product i -> row r = 2r+16
    for (int r = 0; r < N_ROW; r++) exp_rows[r] = 2*r + 16;
    push_tile();
    out_ready = 1'b0;
    w = '0;
    for (int i = 0; i < N_UNIT; i++)
      w[i*DW_OUT +: DW_OUT] = lane(i, i % N_ROW, 1'b1, i == 0);
    beat(w);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_row",   32'(out_row),   32'd7);
      check("bp_hold_data",  32'(out_data),  32'd30);
      check("bp_hold_last",  32'(out_last),  32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drained(100);

    // 4) ping-pong and overrun: three back-to-back last beats, no drain
    pulse_reset();
    out_ready = 1'b0;
    set_rows(2); push_tile();
    set_rows(4); push_tile();
    beat(word_spread(1, 1'b1));
    beat(word_spread(2, 1'b1));
    beat(word_spread(3, 1'b1));
    repeat (3) @(negedge clk);
    check("pp_err_overrun", 32'(err_overrun), 32'd1);
    check("pp_in_ready",    32'(in_ready),    32'd0);
    check("pp_out_valid",   32'(out_valid),   32'd1);
    check("pp_first_data",  32'(out_data),    32'd2);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drained(200);
    check("pp_in_ready_after",   32'(in_ready),    32'd1);
    check("pp_overrun_sticky",   32'(err_overrun), 32'd1);

    // 5) reset while draining row 9, then a fresh tile
    set_rows(2);
    push_tile();
    beat(word_spread(1, 1'b1));
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_row == 4'd9) && n < 50) begin @(negedge clk); n++; end
    check("mid_rst_at_row9", 32'(out_row), 32'd9);
    #1 reset = 1'b0;
    #1 sb.delete();
    check("mid_rst_out_valid",   32'(out_valid),   32'd0);
    check("mid_rst_out_data",    32'(out_data),    32'd0);
    check("mid_rst_out_row",     32'(out_row),     32'd0);
    check("mid_rst_out_last",    32'(out_last),    32'd0);
    check("mid_rst_err_overrun", 32'(err_overrun), 32'd0);
    check("mid_rst_in_ready",    32'(in_ready),    32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    set_rows(6);
    push_tile();
    beat(word_spread(3, 1'b1));
    wait_drained(100);

    // 6) long accumulation into row 0: 600 x 32 x 127 = 2438400
    set_rows(0);
    exp_rows[0] = 2438400;
    push_tile();
    for (int k = 0; k < 600; k++) begin
      w = '0;
      for (int i = 0; i < N_UNIT; i++)
        w[i*DW_OUT +: DW_OUT] = lane(127, 0, 1'b1, (i == 0) && (k == 599));
      beat(w);
    end
    wait_drained(100);
    check("final_err_overrun", 32'(err_overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
